// File: rtl/step_motion_sequencer.sv
// Avalon-MM trapezoidal step/dir sequencer: period ramps P_START->P_MIN, cruises, then ramps back down.
// Register reads return one cycle after the read strobe; waitrequest is never asserted.
module step_motion_sequencer #(
   parameter int PULSE_W   = 50,
   parameter int DIR_SETUP = 10
) (
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset,
   input  logic [2:0]  avs_ctrl_address,
   input  logic [31:0] avs_ctrl_writedata,
   input  logic [3:0]  avs_ctrl_byteenable,
   input  logic        avs_ctrl_write,
   input  logic        avs_ctrl_read,
   output logic [31:0] avs_ctrl_readdata,
   output logic        avs_ctrl_waitrequest,
   output logic        step_out,
   output logic        dir_out,
   output logic        enable_out,
   output logic        irq
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCEL  = 3'd2,
      CRUISE = 3'd3,
      DECEL  = 3'd4
   } state_t;

   localparam logic [31:0] P_FLOOR  = 32'(PULSE_W + 1);
   localparam logic [31:0] SETUP_LD = 32'(DIR_SETUP - 1);
   localparam logic [31:0] PW_LD    = 32'(PULSE_W - 1);

   state_t      state, state_nxt;
   logic [31:0] reg_steps, reg_p_start, reg_p_min, reg_p_delta;
   logic        ctrl_dir, ctrl_enable, ctrl_irq_en;
   logic        done, halted;
   logic [31:0] position;
   logic [31:0] rem, ramp, period, pmin;
   logic [31:0] int_cnt, pw_cnt;
   logic [31:0] per_nxt, ramp_nxt;
   logic [31:0] rem_base, ramp_base;
   logic [32:0] acc_sub, dec_add;
   logic        busy, wr_ctrl, go_ok, start, halt_req, abort_ok;
   logic        issue, finish;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return r;
   endfunction

   assign busy     = (state != IDLE);
   assign wr_ctrl  = avs_ctrl_write && (avs_ctrl_address == 3'd4);
   assign go_ok    = wr_ctrl && avs_ctrl_writedata[0] && avs_ctrl_writedata[3] && !busy;
   assign start    = go_ok && (reg_steps != 32'd0);
   assign halt_req = wr_ctrl && !avs_ctrl_writedata[3] && busy;
   // GO in the same write suppresses ABORT
   assign abort_ok = wr_ctrl && avs_ctrl_writedata[2] && !avs_ctrl_writedata[0]
                     && avs_ctrl_writedata[3] && busy;

   assign acc_sub = {1'b0, period} - {1'b0, reg_p_delta};
   assign dec_add = {1'b0, period} + {1'b0, reg_p_delta};

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) state <= IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      finish    = 1'b0;
      per_nxt   = period;
      ramp_nxt  = ramp;
      case (state)
         IDLE: begin
            if (start) state_nxt = SETUP;
         end
         SETUP: begin
            if (int_cnt == 32'd0) begin
               if (rem == 32'd0) begin
                  state_nxt = IDLE;
                  finish    = 1'b1;
               end else begin
                  issue     = 1'b1;
                  state_nxt = (period <= pmin) ? CRUISE : ACCEL;
               end
            end
         end
         ACCEL, CRUISE, DECEL: begin
            if (int_cnt == 32'd0) begin
               if (rem == 32'd0) begin
                  state_nxt = IDLE;
                  finish    = 1'b1;
               end else begin
                  issue = 1'b1;
                  if (state == DECEL || rem <= ramp) begin
                     state_nxt = DECEL;
                     if (ramp != 32'd0) begin
                        per_nxt  = dec_add[32] ? 32'hFFFF_FFFF : dec_add[31:0];
                        ramp_nxt = ramp - 32'd1;
                     end
                  end else if (state == ACCEL) begin
                     ramp_nxt = ramp + 32'd1;
                     // a borrow means the subtraction went below zero, so clamp as well
                     if (acc_sub[32] || acc_sub[31:0] <= pmin) begin
                        per_nxt   = pmin;
                        state_nxt = CRUISE;
                     end else begin
                        per_nxt = acc_sub[31:0];
                     end
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (halt_req) begin
         state_nxt = IDLE;
         issue     = 1'b0;
         finish    = 1'b0;
      end
   end

   assign rem_base  = issue ? rem - 32'd1 : rem;
   assign ramp_base = issue ? ramp_nxt : ramp;

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         reg_steps   <= '0;
         reg_p_start <= '0;
         reg_p_min   <= '0;
         reg_p_delta <= '0;
         ctrl_dir    <= 1'b0;
         ctrl_enable <= 1'b0;
         ctrl_irq_en <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
         position    <= '0;
         rem         <= '0;
         ramp        <= '0;
         period      <= '0;
         pmin        <= '0;
         int_cnt     <= '0;
         pw_cnt      <= '0;
         step_out    <= 1'b0;
         dir_out     <= 1'b0;
      end else begin
         if (avs_ctrl_write) begin
            case (avs_ctrl_address)
               3'd0: reg_steps   <= be_merge(reg_steps, avs_ctrl_writedata, avs_ctrl_byteenable);
               3'd1: reg_p_start <= be_merge(reg_p_start, avs_ctrl_writedata, avs_ctrl_byteenable);
               3'd2: reg_p_min   <= be_merge(reg_p_min, avs_ctrl_writedata, avs_ctrl_byteenable);
               3'd3: reg_p_delta <= be_merge(reg_p_delta, avs_ctrl_writedata, avs_ctrl_byteenable);
               3'd4: begin
                  ctrl_dir    <= avs_ctrl_writedata[1];
                  ctrl_enable <= avs_ctrl_writedata[3];
                  ctrl_irq_en <= avs_ctrl_writedata[4];
               end
               3'd6: if (!busy) position <= be_merge(position, avs_ctrl_writedata, avs_ctrl_byteenable);
               default: ;
            endcase
         end

         if (go_ok) begin
            done   <= (reg_steps == 32'd0);
            halted <= 1'b0;
         end
         if (finish)   done   <= 1'b1;
         if (halt_req) halted <= 1'b1;

         if (start) begin
            period  <= (reg_p_start > P_FLOOR) ? reg_p_start : P_FLOOR;
            pmin    <= (reg_p_min > P_FLOOR) ? reg_p_min : P_FLOOR;
            ramp    <= '0;
            dir_out <= avs_ctrl_writedata[1];
         end else if (issue) begin
            period <= per_nxt;
            ramp   <= ramp_nxt;
         end

         if (start)         rem <= reg_steps;
         else if (abort_ok) rem <= (rem_base < ramp_base) ? rem_base : ramp_base;
         else if (issue)    rem <= rem_base;

         if (start)                  int_cnt <= SETUP_LD;
         else if (issue)             int_cnt <= per_nxt - 32'd1;
         else if (int_cnt != 32'd0)  int_cnt <= int_cnt - 32'd1;

         if (issue) position <= dir_out ? position + 32'd1 : position - 32'd1;

         if (halt_req) begin
            step_out <= 1'b0;
         end else if (issue) begin
            step_out <= 1'b1;
            pw_cnt   <= PW_LD;
         end else if (step_out) begin
            if (pw_cnt == 32'd0) step_out <= 1'b0;
            else                 pw_cnt   <= pw_cnt - 32'd1;
         end
      end
   end

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         avs_ctrl_readdata <= '0;
      end else if (avs_ctrl_read) begin
         case (avs_ctrl_address)
            3'd0: avs_ctrl_readdata <= reg_steps;
            3'd1: avs_ctrl_readdata <= reg_p_start;
            3'd2: avs_ctrl_readdata <= reg_p_min;
            3'd3: avs_ctrl_readdata <= reg_p_delta;
            3'd4: avs_ctrl_readdata <= {27'd0, ctrl_irq_en, ctrl_enable, 1'b0, ctrl_dir, 1'b0};
            3'd5: avs_ctrl_readdata <= {26'd0, state, halted, done, busy};
            3'd6: avs_ctrl_readdata <= position;
            3'd7: avs_ctrl_readdata <= rem;
            default: avs_ctrl_readdata <= '0;
         endcase
      end
   end

   assign avs_ctrl_waitrequest = 1'b0;
   assign enable_out           = ctrl_enable;
   assign irq                  = done & ctrl_irq_en;

endmodule

// File: tb/tb_step_motion_sequencer.sv
// Bench for step_motion_sequencer: expected step intervals are queued as each move is started
// and checked against measured rising-edge spacing of step_out.
module tb_step_motion_sequencer;
   localparam int PW = 4;
   localparam int DS = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  address;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        write, read;
   logic [31:0] readdata;
   logic        waitrequest, step_out, dir_out, enable_out, irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int mark    = 0;
   int rise    = 0;
   int pulses  = 0;
   logic step_q  = 1'b0;
   logic skip_pw = 1'b0;
   int exp_q[$];

   always #5 clk = ~clk;

   step_motion_sequencer #(.PULSE_W(PW), .DIR_SETUP(DS)) dut (
      .csi_MCLK_clk         (clk),
      .rsi_MRST_reset       (rst),
      .avs_ctrl_address     (address),
      .avs_ctrl_writedata   (writedata),
      .avs_ctrl_byteenable  (byteenable),
      .avs_ctrl_write       (write),
      .avs_ctrl_read        (read),
      .avs_ctrl_readdata    (readdata),
      .avs_ctrl_waitrequest (waitrequest),
      .step_out             (step_out),
      .dir_out              (dir_out),
      .enable_out           (enable_out),
      .irq                  (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // one clock; samples outputs on the falling edge and scores step pulses
   task automatic tick();
      int e;
      @(negedge clk);
      cyc++;
      if (step_out && !step_q) begin
         if (exp_q.size() == 0) begin
            check("extra_pulse", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("interval", 32'(cyc - mark), 32'(e));
         end
         mark = cyc;
         rise = cyc;
         pulses++;
      end
      if (!step_out && step_q && !skip_pw) check("pulse_w", 32'(cyc - rise), 32'(PW));
      step_q = step_out;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      address    = a;
      writedata  = d;
      byteenable = be;
      write      = 1'b1;
      tick();
      write      = 1'b0;
   endtask

   task automatic go(input logic [31:0] ctrl);
      mark = cyc + 1;
      wr(3'd4, ctrl, 4'hF);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      read    = 1'b1;
      tick();
      read    = 1'b0;
      d       = readdata;
   endtask

   task automatic wait_idle(input int budget);
      logic [31:0] s;
      int n;
      n = 0;
      do begin
         rd(3'd5, s);
         n++;
      end while (s[0] && n < budget);
      check("idle_timeout", {31'd0, s[0]}, 32'd0);
      if (exp_q.size() == 0) check("final_missing", 32'(exp_q.size()), 32'd1);
      else                   check("final_iv", 32'(cyc - mark - 1), 32'(exp_q.pop_front()));
   endtask

   task automatic wait_pulses(input int target, input int budget);
      int n;
      n = 0;
      while (pulses < target && n < budget) begin
         tick();
         n++;
      end
      check("pulse_timeout", 32'(pulses), 32'(target));
   endtask

   task automatic load_profile(input logic [31:0] steps, input logic [31:0] ps,
                               input logic [31:0] pm, input logic [31:0] pd);
      wr(3'd0, steps, 4'hF);
      wr(3'd1, ps, 4'hF);
      wr(3'd2, pm, 4'hF);
      wr(3'd3, pd, 4'hF);
   endtask

   task automatic push_ramp_profile();
      exp_q.push_back(DS);
      exp_q.push_back(100); exp_q.push_back(80); exp_q.push_back(60);
      for (int i = 0; i < 14; i++) exp_q.push_back(40);
      exp_q.push_back(60); exp_q.push_back(80); exp_q.push_back(100);
   endtask

   initial begin
      logic [31:0] d;
      rst = 1'b1; address = '0; writedata = '0; byteenable = '0; write = 1'b0; read = 1'b0;
      repeat (3) tick();
      check("rst_step", {31'd0, step_out}, 32'd0);
      check("rst_en", {31'd0, enable_out}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_dir", {31'd0, dir_out}, 32'd0);
      check("rst_rdata", readdata, 32'd0);
      rst = 1'b0;
      tick();
      rd(3'd5, d); check("rst_status", d, 32'd0);
      rd(3'd6, d); check("rst_pos", d, 32'd0);

      // constant-period move, forward
      load_profile(32'd10, 32'd20, 32'd20, 32'd0);
      exp_q.push_back(DS);
      for (int i = 0; i < 10; i++) exp_q.push_back(20);
      pulses = 0;
      go(32'h1B);
      wait_idle(3000);
      check("t2_pulses", 32'(pulses), 32'd10);
      check("t2_left", 32'(exp_q.size()), 32'd0);
      rd(3'd6, d); check("t2_pos", d, 32'd10);
      rd(3'd5, d); check("t2_status", d, 32'h2);
      check("t2_irq", {31'd0, irq}, 32'd1);
      check("t2_dir", {31'd0, dir_out}, 32'd1);

      // full trapezoid, forward
      load_profile(32'd20, 32'd100, 32'd40, 32'd20);
      push_ramp_profile();
      pulses = 0;
      go(32'h1B);
      wait_idle(5000);
      check("t3_pulses", 32'(pulses), 32'd20);
      rd(3'd7, d); check("t3_rem", d, 32'd0);
      rd(3'd5, d); check("t3_status", d, 32'h2);
      rd(3'd6, d); check("t3_pos", d, 32'd30);

      // short move never reaches cruise, reverse
      wr(3'd0, 32'd4, 4'hF);
      exp_q.push_back(DS);
      exp_q.push_back(100); exp_q.push_back(80); exp_q.push_back(60); exp_q.push_back(80);
      pulses = 0;
      go(32'h19);
      wait_idle(3000);
      check("t4_pulses", 32'(pulses), 32'd4);
      check("t4_dir", {31'd0, dir_out}, 32'd0);
      rd(3'd6, d); check("t4_pos", d, 32'd26);
      rd(3'd5, d); check("t4_status", d, 32'h2);

      // abort during cruise ramps down over the accumulated ramp
      wr(3'd0, 32'd1000, 4'hF);
      exp_q.push_back(DS);
      exp_q.push_back(100); exp_q.push_back(80); exp_q.push_back(60);
      for (int i = 0; i < 4; i++) exp_q.push_back(40);
      pulses = 0;
      go(32'h1B);
      wait_pulses(8, 3000);
      exp_q.push_back(40); exp_q.push_back(60); exp_q.push_back(80); exp_q.push_back(100);
      wr(3'd4, 32'h1E, 4'hF);
      wait_idle(3000);
      check("t5_pulses", 32'(pulses), 32'd11);
      rd(3'd6, d); check("t5_pos", d, 32'd37);
      rd(3'd5, d); check("t5_status", d, 32'h2);
      rd(3'd7, d); check("t5_rem", d, 32'd0);
      rd(3'd4, d); check("t5_ctrl", d, 32'h1A);

      // ENABLE dropped mid-pulse in cruise; GO and POSITION writes while busy ignored
      exp_q.push_back(DS);
      exp_q.push_back(100); exp_q.push_back(80); exp_q.push_back(60);
      exp_q.push_back(40); exp_q.push_back(40);
      pulses = 0;
      go(32'h1B);
      wait_pulses(6, 3000);
      skip_pw = 1'b1;
      wr(3'd6, 32'h55, 4'hF);
      wr(3'd4, 32'h1B, 4'hF);
      wr(3'd4, 32'h12, 4'hF);
      check("t6_step_drop", {31'd0, step_out}, 32'd0);
      check("t6_en", {31'd0, enable_out}, 32'd0);
      repeat (200) tick();
      skip_pw = 1'b0;
      check("t6_pulses", 32'(pulses), 32'd6);
      rd(3'd5, d); check("t6_status", d, 32'h4);
      rd(3'd6, d); check("t6_pos", d, 32'd43);
      check("t6_irq", {31'd0, irq}, 32'd0);

      // byte-lane write to POSITION while idle
      wr(3'd6, 32'hFFFF_FFFF, 4'b0010);
      rd(3'd6, d); check("be_pos", d, 32'h0000_FF2B);

      // GO without ENABLE ignored; GO with STEPS==0 completes at once
      wr(3'd0, 32'd0, 4'hF);
      wr(3'd4, 32'h11, 4'hF);
      rd(3'd5, d); check("go_noen", d, 32'h4);
      go(32'h1B);
      repeat (20) tick();
      rd(3'd5, d); check("zero_steps", d, 32'h2);
      check("zero_irq", {31'd0, irq}, 32'd1);

      // reset in the middle of a move
      load_profile(32'd5, 32'd100, 32'd40, 32'd20);
      exp_q.push_back(DS); exp_q.push_back(100);
      pulses = 0;
      go(32'h1B);
      wait_pulses(2, 3000);
      skip_pw = 1'b1;
      rst = 1'b1;
      repeat (2) tick();
      check("mrst_step", {31'd0, step_out}, 32'd0);
      check("mrst_en", {31'd0, enable_out}, 32'd0);
      check("mrst_dir", {31'd0, dir_out}, 32'd0);
      rst = 1'b0;
      tick();
      skip_pw = 1'b0;
      rd(3'd5, d); check("mrst_status", d, 32'd0);
      rd(3'd6, d); check("mrst_pos", d, 32'd0);
      repeat (150) tick();
      check("mrst_pulses", 32'(pulses), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
